// File: rtl/wb_host_pkg.sv
// Shared types and default sizing for the Wishbone host master and its bench.
package wb_host_pkg;

  localparam int DEF_DW      = 8;
  localparam int DEF_AW      = 1;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-occupancy counter: cleared when a command is taken, counts each enabled cycle,
// and flags the last permitted cycle so the master can abort instead of wrapping.
module wb_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign expired = (count_reg == LAST);

endmodule

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone pipelined master: one host command becomes one bus
// transaction, answered by read data or a timeout error on the response channel.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic          i_cmd_we,
  input  logic [AW-1:0] i_cmd_addr,
  input  logic [DW-1:0] i_cmd_data,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [DW-1:0] o_rsp_data,
  output logic          o_rsp_err,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic [DW-1:0] i_wb_data,
  output logic          o_busy
);

  state_t        state_reg, state_next;
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] data_reg;
  logic [DW-1:0] rsp_data_reg;
  logic          rsp_err_reg;

  logic cmd_take;
  logic done_ack;
  logic done_timeout;
  logic ctr_enable;
  logic expired;

  assign ctr_enable = (state_reg == ST_REQ) || (state_reg == ST_WAIT);

  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (i_clk),
    .srst    (i_reset),
    .clear   (cmd_take),
    .enable  (ctr_enable),
    .expired (expired)
  );

  always_comb begin
    state_next   = state_reg;
    cmd_take     = 1'b0;
    done_ack     = 1'b0;
    done_timeout = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          cmd_take   = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        // An ack is only meaningful once the strobe has been accepted; an ack on the
        // final counted cycle beats the timeout.
        if (!i_wb_stall && i_wb_ack) begin
          done_ack   = 1'b1;
          state_next = ST_RSP;
        end else if (expired) begin
          done_timeout = 1'b1;
          state_next   = ST_RSP;
        end else if (!i_wb_stall) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_wb_ack) begin
          done_ack   = 1'b1;
          state_next = ST_RSP;
        end else if (expired) begin
          done_timeout = 1'b1;
          state_next   = ST_RSP;
        end
      end
      ST_RSP: begin
        if (i_rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg    <= ST_IDLE;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (cmd_take) begin
        we_reg   <= i_cmd_we;
        addr_reg <= i_cmd_addr;
        data_reg <= i_cmd_data;
      end
      if (done_ack) begin
        rsp_data_reg <= we_reg ? '0 : i_wb_data;
        rsp_err_reg  <= 1'b0;
      end else if (done_timeout) begin
        rsp_data_reg <= '0;
        rsp_err_reg  <= 1'b1;
      end else if (state_reg == ST_RSP && i_rsp_ready) begin
        rsp_data_reg <= '0;
        rsp_err_reg  <= 1'b0;
      end
    end
  end

  assign o_cmd_ready = (state_reg == ST_IDLE);
  assign o_busy      = (state_reg != ST_IDLE);
  assign o_wb_cyc    = ctr_enable;
  assign o_wb_stb    = (state_reg == ST_REQ);
  assign o_wb_we     = we_reg;
  assign o_wb_addr   = addr_reg;
  assign o_wb_data   = data_reg;
  assign o_rsp_valid = (state_reg == ST_RSP);
  assign o_rsp_data  = rsp_data_reg;
  assign o_rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_wb_host_master.sv
// Randomised scoreboard bench for wb_host_master with a scripted Wishbone slave:
// each command carries a stall/ack plan from which the expected response is derived.
module tb_wb_host_master;
  import wb_host_pkg::*;

  localparam int DW = DEF_DW;
  localparam int AW = DEF_AW;
  localparam int TO = DEF_TIMEOUT;

  logic          i_clk;
  logic          i_reset;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_we;
  logic [AW-1:0] i_cmd_addr;
  logic [DW-1:0] i_cmd_data;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [DW-1:0] o_rsp_data;
  logic          o_rsp_err;
  logic          o_wb_cyc;
  logic          o_wb_stb;
  logic          o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [DW-1:0] o_wb_data;
  logic          i_wb_stall;
  logic          i_wb_ack;
  logic [DW-1:0] i_wb_data;
  logic          o_busy;

  wb_host_master #(
    .DW      (DW),
    .AW      (AW),
    .TIMEOUT (TO)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_we    (i_cmd_we),
    .i_cmd_addr  (i_cmd_addr),
    .i_cmd_data  (i_cmd_data),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_err   (o_rsp_err),
    .o_wb_cyc    (o_wb_cyc),
    .o_wb_stb    (o_wb_stb),
    .o_wb_we     (o_wb_we),
    .o_wb_addr   (o_wb_addr),
    .o_wb_data   (o_wb_data),
    .i_wb_stall  (i_wb_stall),
    .i_wb_ack    (i_wb_ack),
    .i_wb_data   (i_wb_data),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] rsp_data;
    logic          err;
    int            lat;
    int            cyc_n;
    int            stb_n;
  } exp_t;

  typedef struct {
    int            s;
    int            a;
    bit            never;
    logic [DW-1:0] rdata;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];

  int n_vec = 0;
  int n_miss = 0;
  int cyc_no = 0;
  int txn_no = 0;
  int ready_low_left = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: ack lands on bus cycle s+a counted from the first strobe; the
  // master may hold the bus for TO cycles, so any later ack means a timeout.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input int s, input int a, input bit never, input logic [DW-1:0] rdata);
    exp_t  e;
    plan_t p;
    bit    acc;
    int    budget;
    e.we       = we;
    e.addr     = addr;
    e.data     = data;
    e.err      = never || (s + a > TO - 1);
    e.rsp_data = (e.err || we) ? '0 : rdata;
    e.lat      = e.err ? TO + 1 : s + a + 2;
    e.cyc_n    = e.err ? TO : s + a + 1;
    e.stb_n    = (s + 1 < TO) ? s + 1 : TO;
    p.s = s; p.a = a; p.never = never; p.rdata = rdata;
    exp_q.push_back(e);
    plan_q.push_back(p);
    i_cmd_valid = 1'b1;
    i_cmd_we    = we;
    i_cmd_addr  = addr;
    i_cmd_data  = data;
    acc = 1'b0;
    budget = 0;
    while (!acc && budget < 200) begin
      @(negedge i_clk);
      acc = o_cmd_ready;
      @(posedge i_clk);
      #1;
      budget++;
    end
    if (!acc) chk("cmd_accept_wait", 64'(acc), 64'd1);
    i_cmd_valid = 1'b0;
    i_cmd_we    = 1'($urandom);
    i_cmd_addr  = AW'($urandom);
    i_cmd_data  = DW'($urandom);
  endtask

  // Scripted slave: stalls s cycles, acks a cycles after acceptance; stray acks
  // are injected while stalled and while the bus is idle.
  bit    sl_active = 1'b0;
  int    sl_k = 0;
  plan_t sl_cur;

  initial begin
    i_wb_stall = 1'b0;
    i_wb_ack   = 1'b0;
    i_wb_data  = '0;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        sl_active = 1'b0;
        plan_q.delete();
        i_wb_stall = 1'b0;
        i_wb_ack   = 1'b0;
      end else if (o_wb_cyc) begin
        if (!sl_active) begin
          if (plan_q.size() > 0) begin
            sl_cur = plan_q.pop_front();
          end else begin
            sl_cur.s = 0; sl_cur.a = 0; sl_cur.never = 1'b1; sl_cur.rdata = '0;
          end
          sl_active = 1'b1;
          sl_k = 0;
        end
        i_wb_stall = (sl_k < sl_cur.s);
        if (!sl_cur.never && sl_k == sl_cur.s + sl_cur.a) begin
          i_wb_ack  = 1'b1;
          i_wb_data = sl_cur.rdata;
        end else begin
          i_wb_ack  = (sl_k < sl_cur.s) ? 1'($urandom) : 1'b0;
          i_wb_data = DW'($urandom);
        end
        sl_k++;
      end else begin
        sl_active  = 1'b0;
        i_wb_stall = 1'($urandom);
        i_wb_ack   = ($urandom % 4) == 0;
        i_wb_data  = DW'($urandom);
      end
    end
  end

  initial begin
    i_rsp_ready = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (o_rsp_valid && ready_low_left > 0) begin
        i_rsp_ready = 1'b0;
        ready_low_left--;
      end else begin
        i_rsp_ready = ($urandom % 3) != 0;
      end
    end
  end

  // Monitor: samples mid-cycle, pops the scoreboard on each new response.
  initial begin
    bit            rst_prev;
    bit            outst;
    bit            held;
    int            acc_cyc;
    int            cyc_n;
    int            stb_n;
    logic [DW-1:0] h_data;
    logic          h_err;
    exp_t          e;
    rst_prev = 1'b0; outst = 1'b0; held = 1'b0;
    acc_cyc = 0; cyc_n = 0; stb_n = 0; h_data = '0; h_err = 1'b0;
    forever begin
      @(negedge i_clk);
      #2;
      cyc_no++;
      if (rst_prev) begin
        chk("reset_cmd_ready", 64'(o_cmd_ready), 64'd1);
        chk("reset_cyc", 64'(o_wb_cyc), 64'd0);
        chk("reset_stb", 64'(o_wb_stb), 64'd0);
        chk("reset_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("reset_busy", 64'(o_busy), 64'd0);
      end
      rst_prev = i_reset;
      if (i_reset) begin
        exp_q.delete();
        outst = 1'b0;
        held  = 1'b0;
      end else begin
        chk("cmd_ready", 64'(o_cmd_ready), 64'(!outst));
        chk("busy", 64'(o_busy), 64'(outst));
        if (o_wb_cyc) cyc_n++;
        if (o_wb_stb) stb_n++;
        if (o_wb_stb && !i_wb_stall && exp_q.size() > 0) begin
          chk("wb_we", 64'(o_wb_we), 64'(exp_q[0].we));
          chk("wb_addr", 64'(o_wb_addr), 64'(exp_q[0].addr));
          chk("wb_data", 64'(o_wb_data), 64'(exp_q[0].data));
        end
        if (o_rsp_valid) begin
          if (!held) begin
            chk("rsp_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk("rsp_data", 64'(o_rsp_data), 64'(e.rsp_data));
              chk("rsp_err", 64'(o_rsp_err), 64'(e.err));
              chk("rsp_latency", 64'(cyc_no - acc_cyc), 64'(e.lat));
              chk("cyc_cycles", 64'(cyc_n), 64'(e.cyc_n));
              chk("stb_cycles", 64'(stb_n), 64'(e.stb_n));
              txn_no++;
              $display("txn %0d: we=%0d addr=%0d rsp_data=0x%02h err=%0d lat=%0d cyc=%0d stb=%0d",
                       txn_no, e.we, e.addr, o_rsp_data, o_rsp_err, cyc_no - acc_cyc, cyc_n, stb_n);
            end
            h_data = o_rsp_data;
            h_err  = o_rsp_err;
            held   = 1'b1;
          end else begin
            chk("rsp_data_stable", 64'(o_rsp_data), 64'(h_data));
            chk("rsp_err_stable", 64'(o_rsp_err), 64'(h_err));
          end
          if (i_rsp_ready) begin
            held  = 1'b0;
            outst = 1'b0;
          end
        end
        if (i_cmd_valid && o_cmd_ready) begin
          outst   = 1'b1;
          acc_cyc = cyc_no;
          cyc_n   = 0;
          stb_n   = 0;
        end
      end
    end
  end

  initial begin
    int r, s, a;
    bit never;
    i_reset     = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_we    = 1'b0;
    i_cmd_addr  = '0;
    i_cmd_data  = '0;
    repeat (4) @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    issue(1'b1, 1'b0, 8'hA5, 0, 1, 1'b0, 8'h00);
    issue(1'b0, 1'b1, 8'h00, 0, 0, 1'b0, 8'h3C);
    issue(1'b0, 1'b0, 8'h11, 3, 2, 1'b0, 8'h5A);
    issue(1'b0, 1'b1, 8'h22, 0, 0, 1'b1, 8'hFF);
    issue(1'b0, 1'b1, 8'h33, 5, TO - 6, 1'b0, 8'h77);
    issue(1'b0, 1'b0, 8'h44, 5, TO - 5, 1'b0, 8'h88);
    issue(1'b1, 1'b1, 8'h55, TO + 2, 0, 1'b0, 8'h99);
    issue(1'b0, 1'b0, 8'h66, TO - 1, 0, 1'b0, 8'hC3);
    issue(1'b0, 1'b1, 8'h00, 1, 1, 1'b0, 8'hE7);
    ready_low_left = 5;
    issue(1'b1, 1'b0, 8'h0F, 0, 0, 1'b0, 8'h00);

    for (int n = 0; n < 60; n++) begin
      r     = int'($urandom_range(0, 7));
      never = (r == 0);
      s     = (r == 1) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
      a     = (r == 2) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
      issue(1'($urandom), AW'($urandom), DW'($urandom), s, a, never, DW'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge i_clk);
        #1;
      end
    end

    // Reset while the master is waiting for an ack that never comes.
    issue(1'b0, 1'b1, 8'h00, 0, 0, 1'b1, 8'h00);
    for (int i = 0; i < 50 && !(o_wb_cyc && !o_wb_stb); i++) begin
      @(posedge i_clk);
      #1;
    end
    chk("reached_wait", 64'(o_wb_cyc && !o_wb_stb), 64'd1);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    repeat (3) begin
      @(posedge i_clk);
      #1;
    end
    issue(1'b0, 1'b0, 8'h00, 1, 0, 1'b0, 8'h6B);

    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge i_clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    repeat (6) @(posedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
